// File: rtl/gb_video_pkg.sv
// Shared GameBoy video definitions: LCD geometry, PPU modes, capture FSM states and the
// RGB555 -> RGB888 expansion used by both the capture path and the VGA mapping.
package gb_video_pkg;

    localparam int unsigned GB_LCD_W = 160;
    localparam int unsigned GB_LCD_H = 144;

    typedef enum logic [1:0] {
        ModeHblank = 2'd0,
        ModeVblank = 2'd1,
        ModeOam    = 2'd2,
        ModeXfer   = 2'd3
    } lcd_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StLine,
        StHwait,
        StDone
    } cap_state_e;

    // Replicate the top bits into the low bits so full-scale 5-bit maps to full-scale 8-bit.
    function automatic logic [23:0] rgb555_to_888(input logic [14:0] c);
        return {c[14:10], c[14:12], c[9:5], c[9:7], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/gb_lcd_pos_counter.sv
// Pixel position tracker for the LCD capture: x within the line, y within the frame and a
// running line base so the linear pixel address needs no multiplier.
module gb_lcd_pos_counter
    import gb_video_pkg::*;
#(
    parameter int unsigned WIDTH  = GB_LCD_W,
    parameter int unsigned HEIGHT = GB_LCD_H,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc_x,
    input  logic              next_line,
    output logic [ADDR_W-1:0] addr,
    output logic              x_full,
    output logic              x_at_end,
    output logic              y_full,
    output logic              y_at_end
);

    localparam int unsigned XW = $clog2(WIDTH + 1);
    localparam int unsigned YW = $clog2(HEIGHT + 2);

    localparam logic [XW-1:0]     XMax   = XW'(WIDTH);
    localparam logic [YW-1:0]     YMax   = YW'(HEIGHT);
    localparam logic [YW-1:0]     YSat   = '1;
    localparam logic [ADDR_W-1:0] Stride = ADDR_W'(WIDTH);

    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] base_q;

    always_ff @(posedge clk_sys) begin
        if (reset || clear) begin
            x_q    <= '0;
            y_q    <= '0;
            base_q <= '0;
        end else if (next_line) begin
            x_q <= '0;
            // y keeps counting past the visible area so short/long frames can be judged.
            if (y_q != YSat) begin
                y_q <= y_q + YW'(1);
            end
            if (y_q < YMax) begin
                base_q <= base_q + Stride;
            end
        end else if (inc_x && (x_q < XMax)) begin
            x_q <= x_q + XW'(1);
        end
    end

    assign addr     = base_q + ADDR_W'(x_q);
    assign x_full   = (x_q >= XMax);
    assign x_at_end = (x_q == XMax);
    assign y_full   = (y_q >= YMax);
    assign y_at_end = (y_q == YMax);

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the GameBoy core LCD pixel stream into a linear, optionally double-banked RGB888
// framebuffer, flagging malformed lines/frames and pulsing frame_done per completed frame.
module gb_lcd_capture
    import gb_video_pkg::*;
#(
    parameter int unsigned WIDTH   = GB_LCD_W,
    parameter int unsigned HEIGHT  = GB_LCD_H,
    parameter int unsigned ADDR_W  = 15,
    parameter bit          DBL_BUF = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              lcd_clkena,
    input  logic [14:0]       lcd_data,
    input  logic [1:0]        lcd_mode,
    input  logic              lcd_on,
    input  logic              lcd_vsync,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_bank,
    output logic [23:0]       fb_data,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              err_line,
    output logic              err_frame
);

    cap_state_e        state_q;
    logic              vsync_q;
    logic [1:0]        mode_q;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [23:0]       fb_data_q;
    logic              bank_q;
    logic              frame_done_q;
    logic [15:0]       frame_count_q;
    logic              err_line_q;
    logic              err_frame_q;

    logic              vsync_rise;
    logic              mode3_exit;
    logic              lcd_off;
    logic              pix;
    logic              cnt_clear;
    logic              cnt_inc;
    logic              cnt_next;
    logic              pix_write;
    logic [ADDR_W-1:0] pos_addr;
    logic              x_full;
    logic              x_at_end;
    logic              y_full;
    logic              y_at_end;

    assign vsync_rise = lcd_vsync & ~vsync_q;
    assign mode3_exit = (mode_q == ModeXfer) && (lcd_mode != ModeXfer);
    assign lcd_off    = ~lcd_on;
    assign pix        = lcd_clkena && (lcd_mode == ModeXfer);

    gb_lcd_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .clear     (cnt_clear),
        .inc_x     (cnt_inc),
        .next_line (cnt_next),
        .addr      (pos_addr),
        .x_full    (x_full),
        .x_at_end  (x_at_end),
        .y_full    (y_full),
        .y_at_end  (y_at_end)
    );

    // Lines past the visible height still advance x so their length is checked, but never write.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        cnt_next  = 1'b0;
        pix_write = 1'b0;
        case (state_q)
            StIdle, StSync: cnt_clear = 1'b1;
            StLine: begin
                if (!lcd_off) begin
                    if (mode3_exit || vsync_rise) begin
                        cnt_next = 1'b1;
                    end else if (pix && !x_full) begin
                        cnt_inc   = 1'b1;
                        pix_write = !y_full;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= StIdle;
            vsync_q       <= 1'b0;
            mode_q        <= 2'd0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            bank_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
        end else begin
            vsync_q      <= lcd_vsync;
            mode_q       <= lcd_mode;
            fb_we_q      <= pix_write;
            frame_done_q <= 1'b0;
            if (pix_write) begin
                fb_addr_q <= pos_addr;
                fb_data_q <= rgb555_to_888(lcd_data);
            end
            case (state_q)
                StIdle: begin
                    if (lcd_on && vsync_rise) begin
                        state_q <= StSync;
                    end
                end
                StSync: begin
                    if (lcd_off) begin
                        state_q <= StIdle;
                    end else if (lcd_mode == ModeXfer) begin
                        state_q <= StLine;
                    end
                end
                StLine: begin
                    if (lcd_off) begin
                        state_q <= StIdle;
                    end else if (mode3_exit || vsync_rise) begin
                        if (!x_at_end) begin
                            err_line_q <= 1'b1;
                        end
                        state_q <= vsync_rise ? StDone : StHwait;
                    end else if (pix && x_full) begin
                        err_line_q <= 1'b1;
                    end else if (pix && y_full) begin
                        err_frame_q <= 1'b1;
                    end
                end
                StHwait: begin
                    if (lcd_off) begin
                        state_q <= StIdle;
                    end else if (vsync_rise) begin
                        state_q <= StDone;
                    end else if (lcd_mode == ModeXfer) begin
                        if (y_full) begin
                            err_frame_q <= 1'b1;
                        end
                        state_q <= StLine;
                    end
                end
                StDone: begin
                    if (lcd_off) begin
                        state_q <= StIdle;
                    end else begin
                        if (!y_at_end) begin
                            err_frame_q <= 1'b1;
                        end
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                        bank_q        <= bank_q ^ DBL_BUF;
                        state_q       <= StSync;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_bank     = bank_q;
    assign fb_data     = fb_data_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: scoreboarded pixel writes, per-cycle write latency model,
// frame/error bookkeeping, and a DBL_BUF=0 instance riding on the same stimulus.
module tb_gb_lcd_capture;

    localparam int W = 160;
    localparam int H = 144;

    typedef struct packed {
        logic [14:0] addr;
        logic [23:0] data;
        logic        bank;
    } wr_t;

    logic        clk_sys    = 1'b0;
    logic        reset      = 1'b1;
    logic        lcd_clkena = 1'b0;
    logic [14:0] lcd_data   = '0;
    logic [1:0]  lcd_mode   = 2'd0;
    logic        lcd_on     = 1'b0;
    logic        lcd_vsync  = 1'b0;

    logic        fb_we, fb_bank, frame_done, err_line, err_frame;
    logic [14:0] fb_addr;
    logic [23:0] fb_data;
    logic [15:0] frame_count;

    logic        fb_we_b, fb_bank_b, frame_done_b, err_line_b, err_frame_b;
    logic [14:0] fb_addr_b;
    logic [23:0] fb_data_b;
    logic [15:0] frame_count_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    int          we_cnt   = 0;
    int          done_cnt = 0;
    logic [14:0] last_addr = '0;
    logic        exp_bank = 1'b0;
    logic        acc_now  = 1'b0;
    logic        acc_d    = 1'b0;

    gb_lcd_capture #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .ADDR_W  (15),
        .DBL_BUF (1'b1)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .lcd_clkena  (lcd_clkena),
        .lcd_data    (lcd_data),
        .lcd_mode    (lcd_mode),
        .lcd_on      (lcd_on),
        .lcd_vsync   (lcd_vsync),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_bank     (fb_bank),
        .fb_data     (fb_data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err_line    (err_line),
        .err_frame   (err_frame)
    );

    gb_lcd_capture #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .ADDR_W  (15),
        .DBL_BUF (1'b0)
    ) dut_b (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .lcd_clkena  (lcd_clkena),
        .lcd_data    (lcd_data),
        .lcd_mode    (lcd_mode),
        .lcd_on      (lcd_on),
        .lcd_vsync   (lcd_vsync),
        .fb_we       (fb_we_b),
        .fb_addr     (fb_addr_b),
        .fb_bank     (fb_bank_b),
        .fb_data     (fb_data_b),
        .frame_done  (frame_done_b),
        .frame_count (frame_count_b),
        .err_line    (err_line_b),
        .err_frame   (err_frame_b)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [23:0] exp_rgb(input logic [14:0] c);
        logic [4:0] r, g, b;
        r = c[14:10];
        g = c[9:5];
        b = c[4:0];
        return {r, r[4:2], g, g[4:2], b, b[4:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic vsync_pulse();
        lcd_vsync = 1'b1;
        tick();
        lcd_vsync = 1'b0;
        repeat (3) tick();
    endtask

    // One mode-3 period: a lead-in cycle, n strobes, then the drop back to HBlank.
    task automatic drive_line(input int y, input int n, input bit cap, input bit white);
        wr_t e;
        lcd_mode = 2'd3;
        tick();
        for (int i = 0; i < n; i++) begin
            lcd_clkena = 1'b1;
            lcd_data   = white ? 15'h7FFF : 15'($urandom);
            acc_now    = cap && (i < W) && (y < H);
            if (acc_now) begin
                e.addr = 15'(y * W + i);
                e.data = exp_rgb(lcd_data);
                e.bank = exp_bank;
                exp_q.push_back(e);
            end
            tick();
        end
        lcd_clkena = 1'b0;
        acc_now    = 1'b0;
        lcd_mode   = 2'd0;
        tick();
    endtask

    always @(posedge clk_sys) acc_d <= acc_now;

    always @(negedge clk_sys) begin
        if (!reset) begin
            wr_t e;
            check("we_latency", {31'd0, fb_we}, {31'd0, acc_d});
            check("we_latency_b", {31'd0, fb_we_b}, {31'd0, acc_d});
            if (fb_we) begin
                we_cnt++;
                last_addr = fb_addr;
                check("sb_nonempty_on_we", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", {17'd0, fb_addr}, {17'd0, e.addr});
                    check("wr_data", {8'd0, fb_data}, {8'd0, e.data});
                    check("wr_bank", {31'd0, fb_bank}, {31'd0, e.bank});
                    check("wr_addr_b", {17'd0, fb_addr_b}, {17'd0, e.addr});
                    check("wr_data_b", {8'd0, fb_data_b}, {8'd0, e.data});
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("done_not_with_we", {31'd0, fb_we}, 32'd0);
            end
            if (frame_done_b) begin
                check("bank_b_stays_0", {31'd0, fb_bank_b}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check("rst_fb_we", {31'd0, fb_we}, 32'd0);
        check("rst_fb_addr", {17'd0, fb_addr}, 32'd0);
        check("rst_fb_bank", {31'd0, fb_bank}, 32'd0);
        check("rst_fb_data", {8'd0, fb_data}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_err_line", {31'd0, err_line}, 32'd0);
        check("rst_err_frame", {31'd0, err_frame}, 32'd0);
        reset  = 1'b0;
        lcd_on = 1'b1;
        tick();

        // Pixels before any vsync must be ignored.
        drive_line(0, 20, 1'b0, 1'b0);
        drive_line(1, 20, 1'b0, 1'b0);
        check("no_we_before_vsync", we_cnt, 32'd0);

        // Full white frame.
        vsync_pulse();
        for (int y = 0; y < H; y++) drive_line(y, W, 1'b1, 1'b1);
        vsync_pulse();
        exp_bank = 1'b1;
        check("f1_we_count", we_cnt, 32'd23040);
        check("f1_last_addr", {17'd0, last_addr}, 32'h59FF);
        check("f1_last_data", {8'd0, fb_data}, 32'hFFFFFF);
        check("f1_done_count", done_cnt, 32'd1);
        check("f1_frame_count", {16'd0, frame_count}, 32'd1);
        check("f1_bank", {31'd0, fb_bank}, 32'd1);
        check("f1_err_line", {31'd0, err_line}, 32'd0);
        check("f1_err_frame", {31'd0, err_frame}, 32'd0);

        // LCD switched off mid-frame at line 70.
        for (int y = 0; y < 70; y++) drive_line(y, W, 1'b1, 1'b0);
        begin
            wr_t e;
            lcd_mode = 2'd3;
            tick();
            for (int i = 0; i < 40; i++) begin
                lcd_clkena = 1'b1;
                lcd_data   = 15'($urandom);
                acc_now    = 1'b1;
                e.addr     = 15'(70 * W + i);
                e.data     = exp_rgb(lcd_data);
                e.bank     = exp_bank;
                exp_q.push_back(e);
                tick();
            end
        end
        lcd_clkena = 1'b0;
        acc_now    = 1'b0;
        lcd_on     = 1'b0;
        tick();
        lcd_mode = 2'd0;
        repeat (4) tick();
        check("off_done_count", done_cnt, 32'd1);
        check("off_frame_count", {16'd0, frame_count}, 32'd1);
        check("off_bank", {31'd0, fb_bank}, 32'd1);
        check("off_err_line", {31'd0, err_line}, 32'd0);
        check("off_err_frame", {31'd0, err_frame}, 32'd0);

        // Re-enable: stray pixels ignored until vsync, then a clean frame into bank 1.
        lcd_on = 1'b1;
        tick();
        drive_line(0, 10, 1'b0, 1'b0);
        vsync_pulse();
        for (int y = 0; y < H; y++) drive_line(y, W, 1'b1, 1'b0);
        vsync_pulse();
        exp_bank = 1'b0;
        check("f2_done_count", done_cnt, 32'd2);
        check("f2_frame_count", {16'd0, frame_count}, 32'd2);
        check("f2_bank", {31'd0, fb_bank}, 32'd0);
        check("f2_err_line", {31'd0, err_line}, 32'd0);
        check("f2_err_frame", {31'd0, err_frame}, 32'd0);

        // Overlong first line, then only 143 lines in the frame.
        drive_line(0, W + 1, 1'b1, 1'b0);
        check("long_line_err_line", {31'd0, err_line}, 32'd1);
        check("long_line_err_frame", {31'd0, err_frame}, 32'd0);
        for (int y = 1; y < H - 1; y++) drive_line(y, 8, 1'b1, 1'b0);
        vsync_pulse();
        exp_bank = 1'b1;
        check("short_done_count", done_cnt, 32'd3);
        check("short_frame_count", {16'd0, frame_count}, 32'd3);
        check("short_err_frame", {31'd0, err_frame}, 32'd1);
        check("sticky_err_line", {31'd0, err_line}, 32'd1);
        check("short_bank", {31'd0, fb_bank}, 32'd1);
        check("b_frame_count", {16'd0, frame_count_b}, 32'd3);
        check("b_bank", {31'd0, fb_bank_b}, 32'd0);
        check("sb_drained_1", exp_q.size(), 32'd0);

        reset = 1'b1;
        repeat (2) tick();
        reset    = 1'b0;
        exp_bank = 1'b0;
        tick();
        check("rst2_err_line", {31'd0, err_line}, 32'd0);
        check("rst2_err_frame", {31'd0, err_frame}, 32'd0);
        check("rst2_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst2_bank", {31'd0, fb_bank}, 32'd0);

        // Counter preloaded to its maximum; the next completed frame must wrap it to zero.
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        tick();
        vsync_pulse();
        drive_line(0, W, 1'b1, 1'b0);
        vsync_pulse();
        exp_bank = 1'b1;
        check("wrap_frame_count", {16'd0, frame_count}, 32'd0);
        check("wrap_done_count", done_cnt, 32'd4);
        check("wrap_bank", {31'd0, fb_bank}, 32'd1);
        check("wrap_err_frame", {31'd0, err_frame}, 32'd1);
        check("b_wrap_frame_count", {16'd0, frame_count_b}, 32'd1);
        check("b_wrap_bank", {31'd0, fb_bank_b}, 32'd0);
        check("b_wrap_err_frame", {31'd0, err_frame_b}, 32'd1);
        check("b_err_line", {31'd0, err_line_b}, 32'd0);
        check("sb_drained_2", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
